// File: rtl/bcd_line_emitter_if.sv
// Byte-stream and control bundle between the FizzBuzz datapath, the line
// emitter and the downstream UART byte sink.
interface bcd_line_emitter_if;
  logic       start;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       fizz;
  logic       buzz;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  // Emitter side: consumes the request and digits, drives the byte stream.
  modport master (
    input  start, digit2, digit1, digit0, fizz, buzz, out_ready,
    output out_char, out_valid, busy, done
  );

  // Requester/sink side: the mirror image of the emitter.
  modport slave (
    output start, digit2, digit1, digit0, fizz, buzz, out_ready,
    input  out_char, out_valid, busy, done
  );
endinterface

// File: rtl/bcd_line_emitter.sv
// Converts one snapshot of the 3-digit BCD counter plus fizz/buzz flags into
// an ASCII text line ("Fizz", "Buzz", "FizzBuzz" or the decimal value) and
// streams it one byte per transfer over a valid/ready interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; out_valid low
// S_WORD   | streaming "Fizz"/"Buzz"/"FizzBuzz", idx_q is the byte index
// S_DIGITS | streaming decimal digits, pos_q: 0=hundreds 1=tens 2=units
// S_CR     | presenting carriage return (only reachable when EMIT_CR=1)
// S_LF     | presenting line feed; its transfer finishes the line
module bcd_line_emitter #(
  parameter bit EMIT_CR        = 1'b1,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input logic                clk,
  input logic                rst,
  bcd_line_emitter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WORD   = 3'd1,
    S_DIGITS = 3'd2,
    S_CR     = 3'd3,
    S_LF     = 3'd4
  } state_t;

  state_t     state_q;
  logic [3:0] dig2_q;
  logic [3:0] dig1_q;
  logic [3:0] dig0_q;
  logic       fizz_q;
  logic       buzz_q;
  logic [2:0] idx_q;
  logic [1:0] pos_q;
  logic [7:0] char_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;

  logic       xfer_d;
  logic       word_last_d;
  logic [2:0] idx_d;
  logic [1:0] pos_d;
  logic [3:0] next_dig_d;
  logic [1:0] first_pos_d;
  logic [3:0] first_dig_d;
  state_t     term_state_d;
  logic [7:0] term_char_d;

  // Invalid BCD codes print as '?' so a corrupted counter is visible on the line.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (d > 4'd9) begin
      return 8'h3F;
    end
    return 8'h30 + {4'h0, d};
  endfunction

  // Bytes 0..3 spell "Fizz" when fizz is set, otherwise "Buzz"; bytes 4..7
  // only occur for FizzBuzz and always spell "Buzz".
  function automatic logic [7:0] word_char(input logic [2:0] idx, input logic fz);
    logic use_fizz;
    use_fizz = fz && !idx[2];
    case (idx[1:0])
      2'd0:    return use_fizz ? 8'h46 : 8'h42;
      2'd1:    return use_fizz ? 8'h69 : 8'h75;
      default: return 8'h7A;
    endcase
  endfunction

  // Next-byte selection: transfer detect, sequence ends, and the first
  // printable digit so suppressed leading zeros never cost a cycle.
  always_comb begin
    xfer_d      = valid_q && bus.out_ready;
    idx_d       = idx_q + 3'd1;
    pos_d       = pos_q + 2'd1;
    word_last_d = (fizz_q && buzz_q) ? (idx_q == 3'd7) : (idx_q == 3'd3);
    next_dig_d  = (pos_d == 2'd1) ? dig1_q : dig0_q;

    if (!SUPPRESS_ZEROS || (bus.digit2 != 4'd0)) begin
      first_pos_d = 2'd0;
    end else if (bus.digit1 != 4'd0) begin
      first_pos_d = 2'd1;
    end else begin
      first_pos_d = 2'd2;
    end

    case (first_pos_d)
      2'd0:    first_dig_d = bus.digit2;
      2'd1:    first_dig_d = bus.digit1;
      default: first_dig_d = bus.digit0;
    endcase

    term_state_d = EMIT_CR ? S_CR : S_LF;
    term_char_d  = EMIT_CR ? 8'h0D : 8'h0A;
  end

  // Line sequencer with registered byte/handshake outputs; reset abandons
  // any partial line without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dig2_q  <= 4'd0;
      dig1_q  <= 4'd0;
      dig0_q  <= 4'd0;
      fizz_q  <= 1'b0;
      buzz_q  <= 1'b0;
      idx_q   <= 3'd0;
      pos_q   <= 2'd0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dig2_q  <= bus.digit2;
            dig1_q  <= bus.digit1;
            dig0_q  <= bus.digit0;
            fizz_q  <= bus.fizz;
            buzz_q  <= bus.buzz;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            if (bus.fizz || bus.buzz) begin
              state_q <= S_WORD;
              idx_q   <= 3'd0;
              char_q  <= word_char(3'd0, bus.fizz);
            end else begin
              state_q <= S_DIGITS;
              pos_q   <= first_pos_d;
              char_q  <= digit_char(first_dig_d);
            end
          end
        end

        S_WORD: begin
          if (xfer_d) begin
            if (word_last_d) begin
              state_q <= term_state_d;
              char_q  <= term_char_d;
            end else begin
              idx_q  <= idx_d;
              char_q <= word_char(idx_d, fizz_q);
            end
          end
        end

        S_DIGITS: begin
          if (xfer_d) begin
            if (pos_q == 2'd2) begin
              state_q <= term_state_d;
              char_q  <= term_char_d;
            end else begin
              pos_q  <= pos_d;
              char_q <= digit_char(next_dig_d);
            end
          end
        end

        S_CR: begin
          if (xfer_d) begin
            state_q <= S_LF;
            char_q  <= 8'h0A;
          end
        end

        S_LF: begin
          if (xfer_d) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_char  = char_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/bcd_line_emitter.md
Name: bcd_line_emitter

Overview:
- Reader-side consumer for the 3-digit BCD counter (digit2..digit0) in the FizzBuzz datapath.
- On a start pulse it snapshots the digits and fizz/buzz flags, then streams one ASCII text line, one byte at a time, over a valid/ready byte interface toward the UART transmitter.
- Line content: "Fizz", "Buzz", "FizzBuzz", or the decimal number with leading zeros suppressed, followed by the line terminator.

Parameters:
- EMIT_CR, 1: 1 = terminator is CR LF (0x0D 0x0A); 0 = LF only.
- SUPPRESS_ZEROS, 1: 1 = drop leading zero digits (value 000 still prints one "0"); 0 = always print 3 digits.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to emit one line; sampled only in IDLE.
- digit2  input  4  BCD hundreds digit, captured on accepted start.
- digit1  input  4  BCD tens digit, captured on accepted start.
- digit0  input  4  BCD units digit, captured on accepted start.
- fizz  input  1  value divisible by 3, captured on accepted start.
- buzz  input  1  value divisible by 5, captured on accepted start.
- out_char  output  8  ASCII byte presented to the sink.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  high from the cycle after start is accepted until line completion.
- done  output  1  one-cycle pulse after the final byte transfers.

Behaviour:
- Reset: state=IDLE; out_valid=0, out_char=0x00, busy=0, done=0. Applies on any edge with rst=1, including mid-line. The partial line is abandoned and no done is issued.
- Transfer: a byte moves on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_char stays stable and out_valid stays high.
  - out_valid never drops without a transfer, except on reset.
- Start acceptance: start=1 in IDLE at edge N registers the inputs. At N+1: busy=1, out_valid=1, first byte on out_char.
  - start while busy is ignored, not queued.
  - Captured values are used for the whole line. Input changes after capture have no effect.
- FSM states: IDLE -> (WORD | DIGITS) -> CR -> LF -> IDLE.
- WORD (fizz or buzz set):
  - fizz only: "Fizz" (0x46 0x69 0x7A 0x7A).
  - buzz only: "Buzz" (0x42 0x75 0x7A 0x7A).
  - Both: "FizzBuzz".
  - Digits are not printed.
- DIGITS (neither flag set): emit digit2, digit1, digit0 in that order as 0x30+digit.
  - With SUPPRESS_ZEROS=1, leading zeros are skipped; digit0 is always emitted.
  - Skipped digits cost no cycles: the first byte is already the first non-suppressed digit.
  - A digit >9 (invalid BCD) is emitted as '?' (0x3F) and counts as nonzero for suppression.
- CR: state is skipped when EMIT_CR=0.
- LF: on the LF transfer edge, state goes to IDLE. Next cycle: out_valid=0, busy=0, done=1 for exactly one cycle.
  - start is accepted in that done cycle (IDLE); back-to-back lines have a 1-cycle gap.
- Throughput: with out_ready held high, one byte per cycle with no bubbles inside a line.
- out_char holds its last value when out_valid=0; the sink must not sample it.

Test Plan:
- digits 1,2,0, no flags, out_ready=1, start pulse -> bytes 0x31 0x32 0x30 0x0D 0x0A on 5 consecutive cycles starting at start+1, done pulse the cycle after 0x0A, busy high for exactly 5 cycles.
- digits 0,0,7 -> "7\r\n" (3 bytes). digits 0,0,0 -> "0\r\n". With SUPPRESS_ZEROS=0, digits 0,0,7 -> "007\r\n".
- fizz=1 buzz=1, digits 0,1,5 -> "FizzBuzz\r\n" (10 bytes, no digits). fizz only with 0,0,9 -> "Fizz\r\n".
- Backpressure: digits 0,4,2 with out_ready toggling 1,0,0,1,... -> exact sequence "42\r\n", out_char stable and out_valid high across every stalled cycle, no byte duplicated or lost.
- Change digits and pulse start again mid-line -> the line still reflects the original capture and the second start is ignored. A start during the done cycle -> a new line begins on the next cycle.
- Assert rst for 1 cycle after the 2nd byte of "120" -> next cycle out_valid=0, busy=0, done=0. A fresh start then emits a complete correct line. With EMIT_CR=0, digits 0,0,5 -> "5\n" only.
